// File: rtl/row_buffer_loader_pkg.sv
// Shared accelerator-wide types and default sizes for the row buffer loader
// and the layer controller that consumes its rows.
package row_buffer_loader_pkg;

  localparam int DATA_WIDTH_DEF    = 8;
  localparam int ROW_LEN_DEF       = 16;
  localparam int ROW_CNT_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/row_buffer_loader_if.sv
// Stream-in / row-read bus between upstream feeder, loader and controller.
// master = the side driving the loader (upstream + controller), slave = loader.
interface row_buffer_loader_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ROW_CNT_WIDTH = 8
);
  logic                     flush_i;
  logic                     in_valid_i;
  logic [DATA_WIDTH-1:0]    in_data_i;
  logic                     in_ready_o;
  logic                     read_en_i;
  logic                     data_rdy_o;
  logic [DATA_WIDTH-1:0]    rd_data_o;
  logic                     rd_valid_o;
  logic                     row_last_o;
  logic [ROW_CNT_WIDTH-1:0] rows_done_o;
  logic                     underflow_o;

  modport master (
    output flush_i, in_valid_i, in_data_i, read_en_i,
    input  in_ready_o, data_rdy_o, rd_data_o, rd_valid_o, row_last_o,
           rows_done_o, underflow_o
  );

  modport slave (
    input  flush_i, in_valid_i, in_data_i, read_en_i,
    output in_ready_o, data_rdy_o, rd_data_o, rd_valid_o, row_last_o,
           rows_done_o, underflow_o
  );
endinterface

// File: rtl/row_buffer_loader_bank_ctrl.sv
// Per-bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
// Exposes whether the bank may be written or read this cycle.
module row_bank_ctrl
  import row_buffer_loader_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic wr_hit,
  input  logic wr_last,
  input  logic rd_hit,
  input  logic rd_last,
  output logic writable_o,
  output logic readable_o
);

  bank_state_t state_q, state_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BANK_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state: writes advance the fill phase, reads advance the drain phase
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = BANK_EMPTY;
    end else begin
      case (state_q)
        BANK_EMPTY:    if (wr_hit) state_d = wr_last ? BANK_FULL : BANK_FILLING;
        BANK_FILLING:  if (wr_hit && wr_last) state_d = BANK_FULL;
        BANK_FULL:     if (rd_hit) state_d = rd_last ? BANK_EMPTY : BANK_DRAINING;
        BANK_DRAINING: if (rd_hit && rd_last) state_d = BANK_EMPTY;
        default:       state_d = BANK_EMPTY;
      endcase
    end
  end

  // Outputs decoded from registered state only (no comb path from hits)
  always_comb begin
    writable_o = (state_q == BANK_EMPTY) || (state_q == BANK_FILLING);
    readable_o = (state_q == BANK_FULL)  || (state_q == BANK_DRAINING);
  end

endmodule

// File: rtl/row_buffer_loader.sv
// Ping-pong row buffer: packs a word stream into two banks of ROW_LEN words
// and drains a complete row one word per read_en_i while the other bank fills.
module row_buffer_loader
  import row_buffer_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ROW_LEN       = ROW_LEN_DEF,
  parameter int ROW_CNT_WIDTH = ROW_CNT_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  row_buffer_loader_if.slave bus
);

  localparam int PTR_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(ROW_LEN - 1);

  logic [1:0] bank_wr_ok, bank_rd_ok, wr_hit, rd_hit;

  logic                     wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     row_last_q, row_last_d;
  logic [ROW_CNT_WIDTH-1:0] rows_done_q, rows_done_d;
  logic                     underflow_q, underflow_d;

  // Storage is deliberately not reset; contents are only read once written
  logic [DATA_WIDTH-1:0] mem_q [2][ROW_LEN];

  logic in_ready, data_rdy, wr_fire, rd_fire, wr_last, rd_last;

  // Handshake decode; flush drops any concurrent transfer
  always_comb begin
    in_ready = bank_wr_ok[wr_sel_q];
    data_rdy = bank_rd_ok[rd_sel_q];
    wr_fire  = bus.in_valid_i & in_ready & ~bus.flush_i;
    rd_fire  = bus.read_en_i  & data_rdy & ~bus.flush_i;
    wr_last  = (wr_ptr_q == LAST_IDX);
    rd_last  = (rd_ptr_q == LAST_IDX);
  end

  // Two bank controllers; write and read always hit opposite banks
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_hit[b] = wr_fire & (wr_sel_q == 1'(b));
    assign rd_hit[b] = rd_fire & (rd_sel_q == 1'(b));

    row_bank_ctrl u_bank_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (bus.flush_i),
      .wr_hit     (wr_hit[b]),
      .wr_last    (wr_last),
      .rd_hit     (rd_hit[b]),
      .rd_last    (rd_last),
      .writable_o (bank_wr_ok[b]),
      .readable_o (bank_rd_ok[b])
    );
  end

  // Pointer / bank-select / row counter advance; pointers wrap naturally
  always_comb begin
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rows_done_d = rows_done_q;
    if (bus.flush_i) begin
      wr_sel_d    = 1'b0;
      rd_sel_d    = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      rows_done_d = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (wr_last) wr_sel_d = ~wr_sel_q;
      end
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (rd_last) begin
          rd_sel_d    = ~rd_sel_q;
          rows_done_d = rows_done_q + ROW_CNT_WIDTH'(1);
        end
      end
    end
  end

  // Read-port output registers; rd_data holds when no read (also on flush)
  always_comb begin
    rd_valid_d  = rd_fire;
    row_last_d  = rd_fire & rd_last;
    rd_data_d   = rd_fire ? mem_q[rd_sel_q][rd_ptr_q] : rd_data_q;
    underflow_d = bus.flush_i ? 1'b0
                              : (underflow_q | (bus.read_en_i & ~data_rdy));
  end

  // Control and output state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      row_last_q  <= 1'b0;
      rows_done_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      row_last_q  <= row_last_d;
      rows_done_q <= rows_done_d;
      underflow_q <= underflow_d;
    end
  end

  // Row storage write port
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_sel_q][wr_ptr_q] <= bus.in_data_i;
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.data_rdy_o  = data_rdy;
  assign bus.rd_data_o   = rd_data_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.row_last_o  = row_last_q;
  assign bus.rows_done_o = rows_done_q;
  assign bus.underflow_o = underflow_q;

endmodule

// File: tb/tb_row_buffer_loader.sv
// Bench for row_buffer_loader: word-count model of the ping-pong buffer
// compared every cycle, plus directed scenarios with literal expectations.
module tb_row_buffer_loader;

  localparam int L = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  row_buffer_loader_if #(.DATA_WIDTH(8), .ROW_CNT_WIDTH(8)) bus ();

  row_buffer_loader #(.DATA_WIDTH(8), .ROW_LEN(L), .ROW_CNT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: words written / read since reset or flush ----
  int        m_wr, m_rd;
  logic [7:0] exp_mem [128];
  logic [7:0] m_rdata;
  logic      m_rvalid, m_last, m_uf;
  logic      m_in_ready, m_data_rdy;

  // write bank free if mid-row, or fewer than two undrained complete rows
  assign m_in_ready = ((m_wr % L) != 0) || (((m_wr / L) - (m_rd / L)) < 2);
  // a complete row exists that has not been fully drained
  assign m_data_rdy = (m_wr / L) > (m_rd / L);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr <= 0; m_rd <= 0; m_rdata <= 8'h00;
      m_rvalid <= 1'b0; m_last <= 1'b0; m_uf <= 1'b0;
    end else if (bus.flush_i) begin
      m_wr <= 0; m_rd <= 0;
      m_rvalid <= 1'b0; m_last <= 1'b0; m_uf <= 1'b0;
    end else begin
      m_rvalid <= 1'b0;
      m_last   <= 1'b0;
      if (bus.in_valid_i && m_in_ready) begin
        exp_mem[m_wr % 128] <= bus.in_data_i;
        m_wr <= m_wr + 1;
      end
      if (bus.read_en_i && m_data_rdy) begin
        m_rdata  <= exp_mem[m_rd % 128];
        m_rvalid <= 1'b1;
        m_last   <= ((m_rd % L) == L - 1);
        m_rd     <= m_rd + 1;
      end
      if (bus.read_en_i && !m_data_rdy) m_uf <= 1'b1;
    end
  end

  // compare every cycle while out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",  32'(bus.in_ready_o),  32'(m_in_ready));
      chk("data_rdy",  32'(bus.data_rdy_o),  32'(m_data_rdy));
      chk("rd_valid",  32'(bus.rd_valid_o),  32'(m_rvalid));
      chk("rd_data",   32'(bus.rd_data_o),   32'(m_rdata));
      chk("row_last",  32'(bus.row_last_o),  32'(m_last));
      chk("rows_done", 32'(bus.rows_done_o), 32'((m_rd / L) % 256));
      chk("underflow", 32'(bus.underflow_o), 32'(m_uf));
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic wr_word(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = bus.in_ready_o;
      @(posedge clk); #1;
    end
    if (!ok) chk("wr_timeout", 32'(ok), 32'(1));
  endtask

  task automatic rd_word(input logic [7:0] d, input logic last);
    bus.read_en_i = 1'b1;
    @(posedge clk); #1;
    bus.read_en_i = 1'b0;
    chk("lit_rd_valid", 32'(bus.rd_valid_o), 32'(1));
    chk("lit_rd_data",  32'(bus.rd_data_o),  32'(d));
    chk("lit_row_last", 32'(bus.row_last_o), 32'(last));
  endtask

  task automatic do_flush();
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, r, rdone, gaps;
    rst_n = 1'b0;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.in_data_i = 8'h00; bus.read_en_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready_o),  32'(1));
    chk("rst_data_rdy",  32'(bus.data_rdy_o),  32'(0));
    chk("rst_rows_done", 32'(bus.rows_done_o), 32'(0));
    chk("rst_rd_valid",  32'(bus.rd_valid_o),  32'(0));
    chk("rst_rd_data",   32'(bus.rd_data_o),   32'(0));
    chk("rst_underflow", 32'(bus.underflow_o), 32'(0));
    @(posedge clk); #1;

    // fill one row 0x01..0x10, then read it back
    for (int i = 0; i < L; i++) begin
      wr_word(8'(i + 1));
      if (i == L - 2) chk("fill_rdy_early", 32'(bus.data_rdy_o), 32'(0));
    end
    bus.in_valid_i = 1'b0;
    chk("fill_rdy_rise", 32'(bus.data_rdy_o), 32'(1));
    for (int i = 0; i < L; i++) rd_word(8'(i + 1), i == L - 1);
    chk("fill_rows_done", 32'(bus.rows_done_o), 32'(1));
    chk("fill_rdy_fall",  32'(bus.data_rdy_o),  32'(0));

    // ping-pong: 48 words streamed, reading whenever a row is ready
    do_flush();
    w = 0; r = 0; rdone = 0; gaps = 0;
    for (int c = 0; c < 300 && rdone < 3 * L; c++) begin
      bus.in_valid_i = (w < 3 * L);
      bus.in_data_i  = 8'(8'h20 + w);
      bus.read_en_i  = bus.data_rdy_o && (r < 3 * L);
      @(negedge clk);
      if (r > 0 && r < 3 * L && !bus.data_rdy_o) gaps++;
      if (bus.in_valid_i && bus.in_ready_o) w++;
      if (bus.read_en_i) r++;
      @(posedge clk); #1;
      if (bus.rd_valid_o) rdone++;
    end
    bus.in_valid_i = 1'b0;
    bus.read_en_i  = 1'b0;
    chk("pp_words_in",  32'(w),     32'(48));
    chk("pp_words_out", 32'(rdone), 32'(48));
    chk("pp_rdy_gaps",  32'(gaps),  32'(0));
    chk("pp_rows_done", 32'(bus.rows_done_o), 32'(3));
    chk("pp_rd_last",   32'(bus.rd_data_o),   32'(8'h4F));

    // backpressure: 32 words, no reads; word 33 waits for the freed bank
    do_flush();
    for (int i = 0; i < 2 * L; i++) wr_word(8'(8'h40 + i));
    bus.in_data_i = 8'd33;
    chk("bp_stall", 32'(bus.in_ready_o), 32'(0));
    repeat (3) @(posedge clk);
    #1 chk("bp_stall_hold", 32'(bus.in_ready_o), 32'(0));
    for (int i = 0; i < L; i++) begin
      if (i == L - 1) chk("bp_stall_last", 32'(bus.in_ready_o), 32'(0));
      rd_word(8'(8'h40 + i), i == L - 1);
    end
    chk("bp_ready_after", 32'(bus.in_ready_o), 32'(1));
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < L; i++) rd_word(8'(8'h50 + i), i == L - 1);
    chk("bp_rows_done", 32'(bus.rows_done_o), 32'(2));
    chk("bp_partial",   32'(bus.data_rdy_o),  32'(0));

    // underflow: sticky, rd_valid stays low, cleared by flush
    do_flush();
    chk("fl_rd_hold", 32'(bus.rd_data_o), 32'(8'h5F));
    bus.read_en_i = 1'b1;
    @(posedge clk); #1;
    bus.read_en_i = 1'b0;
    chk("uf_no_valid", 32'(bus.rd_valid_o),  32'(0));
    chk("uf_set",      32'(bus.underflow_o), 32'(1));
    repeat (3) @(posedge clk);
    #1 chk("uf_sticky", 32'(bus.underflow_o), 32'(1));
    do_flush();
    chk("uf_clear", 32'(bus.underflow_o), 32'(0));

    // flush mid-fill, then a clean row
    for (int i = 0; i < 7; i++) wr_word(8'(8'hE0 + i));
    bus.in_valid_i = 1'b0;
    do_flush();
    chk("mf_in_ready", 32'(bus.in_ready_o), 32'(1));
    chk("mf_data_rdy", 32'(bus.data_rdy_o), 32'(0));
    for (int i = 0; i < L; i++) wr_word(8'(8'hA0 + i));
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < L; i++) rd_word(8'(8'hA0 + i), i == L - 1);
    chk("mf_rows_done", 32'(bus.rows_done_o), 32'(1));

    // asynchronous reset mid-cycle, mid-row
    for (int i = 0; i < 3; i++) wr_word(8'(8'h70 + i));
    bus.in_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_in_ready",  32'(bus.in_ready_o),  32'(1));
    chk("ar_data_rdy",  32'(bus.data_rdy_o),  32'(0));
    chk("ar_rows_done", 32'(bus.rows_done_o), 32'(0));
    chk("ar_rd_data",   32'(bus.rd_data_o),   32'(0));
    chk("ar_rd_valid",  32'(bus.rd_valid_o),  32'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/row_buffer_loader.md
Name: row_buffer_loader

Overview:
- Upstream feeder for the layer controller FSM.
- Accepts a streamed activation/weight word per cycle over a valid/ready handshake and packs words into a two-bank (ping-pong) row buffer of ROW_LEN words per bank.
- Raises data_rdy_o to the controller when a complete row is resident.
- Drains the row one word per cycle on the controller's read_en_i, so the next row can fill while the current one is consumed.

Parameters:
- DATA_WIDTH, 8, width of one data word.
- ROW_LEN, 16, words per row/bank; power of two, >= 2.
- ROW_CNT_WIDTH, 8, width of rows_done_o counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous clear of both banks and pointers; highest priority after reset.
- in_valid_i  input  1  upstream word valid.
- in_data_i  input  DATA_WIDTH  upstream word.
- in_ready_o  output  1  loader can accept a word this cycle.
- read_en_i  input  1  controller requests next word of the ready row.
- data_rdy_o  output  1  a full row is available in the read bank.
- rd_data_o  output  DATA_WIDTH  registered read word.
- rd_valid_o  output  1  rd_data_o valid; 1-cycle pulse per accepted read.
- row_last_o  output  1  coincides with rd_valid_o for word ROW_LEN-1.
- rows_done_o  output  ROW_CNT_WIDTH  rows fully drained since reset/flush; wraps.
- underflow_o  output  1  sticky: read_en_i seen while data_rdy_o=0.

Behaviour:
- Reset (rst_n=0, async):
  - both banks EMPTY; wr_sel=0, rd_sel=0, wr_ptr=0, rd_ptr=0.
  - Outputs: in_ready_o=1, data_rdy_o=0, rd_data_o=0, rd_valid_o=0, row_last_o=0, rows_done_o=0, underflow_o=0.
- Bank state per bank (2 bits): EMPTY -> FILLING on first write -> FULL on write of word ROW_LEN-1 -> DRAINING on first read -> EMPTY on read of word ROW_LEN-1.
- Write side:
  - in_ready_o = bank[wr_sel] is EMPTY or FILLING (combinational from state regs).
  - A write happens when in_valid_i & in_ready_o. It stores in_data_i at [wr_sel][wr_ptr] and increments wr_ptr.
  - On word ROW_LEN-1: bank -> FULL, wr_ptr wraps to 0, wr_sel toggles.
- Read side:
  - data_rdy_o = bank[rd_sel] is FULL or DRAINING.
  - A read is accepted when read_en_i & data_rdy_o. rd_data_o <= mem[rd_sel][rd_ptr] and rd_valid_o=1 on the next cycle (latency 1). rd_ptr increments.
  - On word ROW_LEN-1: bank -> EMPTY, rd_ptr wraps, rd_sel toggles, rows_done_o += 1 (mod 2^ROW_CNT_WIDTH), and row_last_o=1 with that rd_valid_o.
- rd_data_o holds its last value when rd_valid_o=0.
- read_en_i & !data_rdy_o: no state change, rd_valid_o=0, underflow_o set until reset/flush.
- Simultaneous write and read in the same cycle is legal (they always target different banks).
  - A bank freed by the final read becomes writable the following cycle; in_ready_o does not combinationally depend on read_en_i.
- Both banks FULL: in_ready_o=0 and the upstream stalls. data_rdy_o stays 1 continuously across the bank switch if the second bank is already FULL (back-to-back rows, no bubble).
- flush_i=1 (synchronous):
  - Same state as reset, except rd_data_o holds.
  - Any concurrent write/read that cycle is dropped.
- Reset mid-row: all partial data is discarded. There is no recovery of the partial row.
- Storage is a flop array, 2*ROW_LEN words, not reset (contents don't-care until written).

Decomposition:
- Shared package (accelerator-wide):
  - bank_state_t enum {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING}.
  - Default ROW_LEN=16 and DATA_WIDTH=8 constants, shared with the controller FSM counter thresholds.
- One sub-module, row_bank_ctrl: the per-bank state register plus next-state logic (inputs wr_hit, wr_last, rd_hit, rd_last, flush). Instantiate twice.
- Pointers, select bits, storage and outputs stay in the top.

Test Plan:
- Reset then idle: after rst_n deassert -> in_ready_o=1, data_rdy_o=0, rows_done_o=0; assert rst_n=0 asynchronously mid-cycle -> outputs clear without a clock edge.
- Fill one row: 16 words 0x01..0x10 with in_valid_i held high -> data_rdy_o rises the cycle after the 16th accept; then 16 read_en_i -> rd_data_o=0x01..0x10 each 1 cycle after request; row_last_o with 0x10; rows_done_o=1; data_rdy_o falls.
- Ping-pong: stream 48 words continuously while reading continuously once ready -> in_ready_o drops only when both banks are FULL, no word lost or reordered, rows_done_o=3, data_rdy_o has no gap between rows 1 and 2.
- Backpressure: fill 32 words with no reads -> in_ready_o=0 after word 32; word 33 held on in_data_i is accepted exactly 1 cycle after the 16th read of row 1.
- Underflow: read_en_i=1 while empty -> rd_valid_o stays 0, underflow_o=1 and sticky; cleared by flush_i.
- Flush mid-fill: 7 words written, then flush_i -> in_ready_o=1, data_rdy_o=0; the next 16 words form a clean row read back in order.
